regfile_sb: RTL
===============

# regfile_sb

Parametrised integer register file for the decode stage of the pipelined RV32I core, replacing the fixed 2-read/1-write file. It has NUM_RD_PORTS combinational read ports, one writeback port, and a per-register busy scoreboard that tracks in-flight loads and generates the load-use stall for decode. Writes come from the writeback stage. Reads and stall feed the decode→execute stage registers.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (x0..x[NUM_REGS-1]); range 2..64
- NUM_RD_PORTS, 2, number of read ports; range 1..4
- AW, $clog2(NUM_REGS), register address width (derived, not overridden)

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_regfile  in  1  writeback enable
- rd  in  AW  writeback destination register
- reg_in  in  XLEN  writeback data
- rs_addr  in  NUM_RD_PORTS*AW  read addresses, port i at [i*AW +: AW]
- rs_valid  in  NUM_RD_PORTS  port i operand is actually used by the decoded instruction
- rs_data  out  NUM_RD_PORTS*XLEN  read data, port i at [i*XLEN +: XLEN]
- sb_set  in  1  a load targeting sb_addr issues out of decode this cycle
- sb_addr  in  AW  load destination to mark busy
- flush  in  1  pipeline flush; clears all busy bits
- rs_busy  out  NUM_RD_PORTS  port i reads a register with a pending load
- stall  out  1  OR over i of (rs_busy[i] & rs_valid[i])

## Operation
- Storage: NUM_REGS × XLEN array `data`, and NUM_REGS-bit `busy` vector.
- Write: if ld_regfile, rd != 0 and rd < NUM_REGS, then data[rd] ← reg_in at the clock edge. Otherwise the write is ignored.
- x0: always reads 0. Writes to x0 are dropped. busy[0] is never set.
- Read port i: rs_data[i] = 0 if addr==0 or addr ≥ NUM_REGS; otherwise data[addr]. Bypass is applied per Configuration.
- Scoreboard, per edge, in priority order:
  1. flush clears every busy bit; any simultaneous sb_set is dropped.
  2. sb_set with sb_addr != 0 sets busy[sb_addr].
  3. A write (ld_regfile, rd != 0) clears busy[rd], unless step 2 targets the same register this cycle. Set wins, because it marks a newer load.
- rs_busy[i] = busy[addr_i], masked per Configuration. rs_busy[i] is 0 for x0 and out-of-range addresses.
- Multiple read ports may name the same register. Each port resolves independently and identically.

## Timing
- Reset (rst_n low, asynchronous): every data entry = 0 and busy = 0. Consequently rs_data = 0, rs_busy = 0 and stall = 0 while in reset.
- Reads, rs_busy and stall are combinational from the current state and inputs. Read latency is 0 cycles.
- Write-to-architectural-state latency is 1 edge. sb_set takes effect on rs_busy from the cycle after the edge.
- Reset asserted mid-operation discards any pending write or set in that cycle.
- stall only reports the hazard. Decode holds sb_set low while stall is high; the block does not enforce this.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read of register a in the same cycle as a valid write to a (ld_regfile, rd==a, a != 0) returns reg_in.
  - rs_busy for that port is forced to 0 in that cycle.
- REGFILE_BYPASS_EN undefined:
  - The same-cycle read returns the old data[a].
  - rs_busy reflects the stored busy bit, so decode stalls one extra cycle after a load writes back.

## Test plan
- Reset then write: rst_n low→high, ld_regfile=1, rd=3, reg_in=0x97 for one edge. Next cycle rs_addr[0]=3 → rs_data[0]=0x00000097. rs_addr[1]=7 → 0.
- x0: ld_regfile=1, rd=0, reg_in=0xDEADBEEF. Read x0 → 0. sb_set with sb_addr=0 → rs_busy stays 0 and stall=0.
- Bypass:
  - Setup: x7=0x60. Apply ld_regfile=1, rd=7, reg_in=0x64 and rs_addr[0]=7 in the same cycle.
  - With REGFILE_BYPASS_EN: rs_data[0]=0x64 in that cycle.
  - Without it: rs_data[0]=0x60 in that cycle, and 0x64 the following cycle.
- Load-use stall:
  - sb_set=1, sb_addr=5. Next cycle rs_addr[1]=5, rs_valid[1]=1 → rs_busy[1]=1, stall=1.
  - With rs_valid[1]=0 → stall=0.
  - Writeback ld_regfile=1, rd=5: busy bit clears after that edge. With bypass, stall=0 already in the writeback cycle.
- Set/clear collision: busy[9]=1, then apply sb_set with sb_addr=9 and ld_regfile with rd=9 in the same cycle → busy[9] remains 1 afterwards. Then flush=1 with sb_set=1, sb_addr=4 → busy all 0.
- Async reset mid-run: with busy[5]=1 and x3=0x97, drop rst_n between edges → rs_data and stall go to 0 immediately, before any clock edge.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with load-use busy scoreboard (optional bypass: REGFILE_BYPASS_EN)
module regfile_sb #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    localparam int AW          = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ld_regfile,
    input  logic [AW-1:0]                rd,
    input  logic [XLEN-1:0]              reg_in,
    input  logic [NUM_RD_PORTS*AW-1:0]   rs_addr,
    input  logic [NUM_RD_PORTS-1:0]      rs_valid,
    output logic [NUM_RD_PORTS*XLEN-1:0] rs_data,
    input  logic                         sb_set,
    input  logic [AW-1:0]                sb_addr,
    input  logic                         flush,
    output logic [NUM_RD_PORTS-1:0]      rs_busy,
    output logic                         stall
);

    // Register count widened by one bit so the range compare never truncates.
    localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

    logic [XLEN-1:0]     data [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                wr_valid;
    logic                set_valid;

    assign wr_valid  = ld_regfile && (rd != '0) && ({1'b0, rd} < NREGS);
    assign set_valid = sb_set && (sb_addr != '0) && ({1'b0, sb_addr} < NREGS);

    // Scoreboard update: flush beats everything, a new load's set beats a writeback clear.
    always_comb begin
        busy_next = busy;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (wr_valid)
                busy_next[rd] = 1'b0;
            if (set_valid)
                busy_next[sb_addr] = 1'b1;
        end
    end

    // Architectural state; x0 is never written so it stays zero from reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                data[r] <= '0;
            busy <= '0;
        end else begin
            if (wr_valid)
                data[rd] <= reg_in;
            busy <= busy_next;
        end
    end

    // Read ports resolve independently; x0 and out-of-range addresses read as zero and never busy.
    always_comb begin
        logic [AW-1:0] a;
        logic          a_ok;
        rs_data = '0;
        rs_busy = '0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            a    = rs_addr[i*AW +: AW];
            a_ok = (a != '0) && ({1'b0, a} < NREGS);
            if (a_ok) begin
                rs_data[i*XLEN +: XLEN] = data[a];
                rs_busy[i]              = busy[a];
`ifdef REGFILE_BYPASS_EN
                // Same-cycle writeback forwards its data and resolves the pending load.
                if (wr_valid && (rd == a)) begin
                    rs_data[i*XLEN +: XLEN] = reg_in;
                    rs_busy[i]              = 1'b0;
                end
`else
                // No forwarding: decode sees the old value and stalls one extra cycle.
`endif
            end
        end
    end

    assign stall = |(rs_busy & rs_valid);

endmodule
